// File: rtl/tx_cipher_framer.sv
// Transmit cipher framer: XORs AXI-Stream plaintext with PRBS or ChaCha20 keystream and frames it.
// Optional build macro TX_CIPHER_FRAMER_STATS_EN enables the completed-frame counter on o_frame_count.
module tx_cipher_framer #(
  parameter int C_LEN_WIDTH = 16
) (
  input  logic                   s_axi_aclk,
  input  logic                   s_axi_areset,
  input  logic                   i_enable,
  input  logic                   i_encrypt_type,
  input  logic [C_LEN_WIDTH-1:0] i_frame_len,
  input  logic [31:0]            i_prbs_data,
  output logic                   o_prbs_run,
  input  logic [31:0]            i_keystream_data,
  input  logic                   i_keystream_valid,
  output logic                   o_keystream_ready,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [31:0]            s_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [31:0]            m_axis_tdata,
  output logic                   m_axis_sof,
  output logic                   m_axis_eof,
  output logic                   o_busy,
  output logic [C_LEN_WIDTH-1:0] o_frame_count,
  output logic [1:0]             o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;

  localparam logic MODE_PRBS   = 1'b0;
  localparam logic MODE_CHACHA = 1'b1;

  localparam logic [C_LEN_WIDTH-1:0] LEN_ZERO = '0;
  localparam logic [C_LEN_WIDTH-1:0] LEN_ONE  = C_LEN_WIDTH'(1);

  // Frame control state
  logic [1:0]             state_q, state_d;
  logic [C_LEN_WIDTH-1:0] len_q, len_d;
  logic [C_LEN_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic                   mode_q, mode_d;

  // Output buffer: two entries of {data[31:0], sof, eof}
  logic [33:0] ent0_q, ent0_d;
  logic [33:0] ent1_q, ent1_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  fill_q, fill_d;

  logic                   active;
  logic                   buf_full;
  logic                   key_ok;
  logic                   acc;
  logic                   pop;
  logic                   first_word;
  logic                   last_word;
  logic                   frame_done;
  logic [31:0]            key;
  logic [33:0]            push_entry;
  logic [33:0]            head;
  logic [C_LEN_WIDTH-1:0] len_clamped;

  // Handshake: a beat transfers on any rising edge where valid and ready are both high.
  // Valid never waits on ready; once raised, valid and its payload hold until the transfer.
  assign active     = (state_q != S_IDLE);
  assign buf_full   = (fill_q == 2'd2);
  assign key_ok     = (mode_q == MODE_PRBS) || i_keystream_valid;
  assign s_axis_tready = active && !buf_full && key_ok;
  assign acc        = s_axis_tvalid && s_axis_tready;
  assign pop        = m_axis_tvalid && m_axis_tready;

  assign len_clamped = (i_frame_len == LEN_ZERO) ? LEN_ONE : i_frame_len;
  assign first_word  = (word_cnt_q == LEN_ZERO);
  assign last_word   = (word_cnt_q == (len_q - LEN_ONE));
  assign frame_done  = acc && last_word;

  assign key        = (mode_q == MODE_CHACHA) ? i_keystream_data : i_prbs_data;
  assign push_entry = {s_axis_tdata ^ key, first_word, last_word};

  // Exactly one keystream source advances per accepted word, matching the receive side.
  assign o_prbs_run        = acc && (mode_q == MODE_PRBS);
  assign o_keystream_ready = acc && (mode_q == MODE_CHACHA);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    mode_d     = mode_q;
    word_cnt_d = word_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          state_d    = S_RUN;
          len_d      = len_clamped;
          mode_d     = i_encrypt_type;
          word_cnt_d = LEN_ZERO;
        end
      end
      S_RUN: begin
        if (frame_done) begin
          word_cnt_d = LEN_ZERO;
          if (i_enable) begin
            len_d  = len_clamped;
            mode_d = i_encrypt_type;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          if (acc) begin
            word_cnt_d = word_cnt_q + LEN_ONE;
          end
          // A frame that has started (or starts this cycle) must be finished before idling.
          if (!i_enable) begin
            state_d = (first_word && !acc) ? S_IDLE : S_LAST;
          end
        end
      end
      S_LAST: begin
        if (frame_done) begin
          word_cnt_d = LEN_ZERO;
          state_d    = S_IDLE;
        end else if (acc) begin
          word_cnt_d = word_cnt_q + LEN_ONE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        word_cnt_d = LEN_ZERO;
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_q    <= S_IDLE;
      len_q      <= LEN_ONE;
      mode_q     <= MODE_PRBS;
      word_cnt_q <= LEN_ZERO;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      mode_q     <= mode_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // Pushes are only offered when not full, so push+pop is legal at every fill level.
  always_comb begin
    ent0_d   = ent0_q;
    ent1_d   = ent1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (acc) begin
      if (wr_ptr_q) begin
        ent1_d = push_entry;
      end else begin
        ent0_d = push_entry;
      end
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({acc, pop})
      2'b10:   fill_d = fill_q + 2'd1;
      2'b01:   fill_d = fill_q - 2'd1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      ent0_q   <= '0;
      ent1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      fill_q   <= 2'd0;
    end else begin
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Head entry is a register, so data and markers stay put while the sink stalls.
  assign head          = rd_ptr_q ? ent1_q : ent0_q;
  assign m_axis_tvalid = (fill_q != 2'd0);
  assign m_axis_tdata  = head[33:2];
  assign m_axis_sof    = m_axis_tvalid && head[1];
  assign m_axis_eof    = m_axis_tvalid && head[0];

  assign o_busy      = active || (fill_q != 2'd0);
  assign o_dbg_state = state_q;

`ifdef TX_CIPHER_FRAMER_STATS_EN
  logic [C_LEN_WIDTH-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + LEN_ONE;
    end
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      frame_cnt_q <= LEN_ZERO;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_frame_count = frame_cnt_q;
`else
  assign o_frame_count = LEN_ZERO;
`endif

endmodule

// File: tb/tb_tx_cipher_framer.sv
// Bench for tx_cipher_framer: directed steps plus randomized sessions against a frame-level model.
module tb_tx_cipher_framer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        s_axi_areset = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_encrypt_type = 1'b0;
  logic [15:0] i_frame_len = 16'd1;
  logic [31:0] i_prbs_data = 32'h0;
  logic        o_prbs_run;
  logic [31:0] i_keystream_data = 32'h0;
  logic        i_keystream_valid = 1'b0;
  logic        o_keystream_ready;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] s_axis_tdata = 32'h0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic [31:0] m_axis_tdata;
  logic        m_axis_sof;
  logic        m_axis_eof;
  logic        o_busy;
  logic [15:0] o_frame_count;
  logic [1:0]  o_dbg_state;

  always #5 clk = ~clk;

  tx_cipher_framer #(.C_LEN_WIDTH(16)) dut (
    .s_axi_aclk        (clk),
    .s_axi_areset      (s_axi_areset),
    .i_enable          (i_enable),
    .i_encrypt_type    (i_encrypt_type),
    .i_frame_len       (i_frame_len),
    .i_prbs_data       (i_prbs_data),
    .o_prbs_run        (o_prbs_run),
    .i_keystream_data  (i_keystream_data),
    .i_keystream_valid (i_keystream_valid),
    .o_keystream_ready (o_keystream_ready),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tdata      (s_axis_tdata),
    .m_axis_tvalid     (m_axis_tvalid),
    .m_axis_tready     (m_axis_tready),
    .m_axis_tdata      (m_axis_tdata),
    .m_axis_sof        (m_axis_sof),
    .m_axis_eof        (m_axis_eof),
    .o_busy            (o_busy),
    .o_frame_count     (o_frame_count),
    .o_dbg_state       (o_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [33:0] exp_q[$];
  logic [33:0] out_q[$];
  bit          cfg_mode = 1'b0;
  int          cfg_len = 1;
  int          mdl_idx = 0;
  int          mdl_frames = 0;
  int          prbs_pulses = 0;
  int          ks_pulses = 0;
  int          words_out = 0;
  int          tready_bad = 0;
  bit          prbs_adv = 1'b0;
  bit          ks_adv = 1'b0;
  bit          prbs_random = 1'b0;
  bit          ks_random = 1'b0;
  bit          rdy_random = 1'b0;
  int          ks_pattern = 0;
  bit          prev_stall = 1'b0;
  logic [33:0] prev_head = '0;
  logic [31:0] m_key;
  int          m_len;
  bit          m_sof;
  bit          m_eof;
  logic [33:0] m_obs;
  logic [33:0] m_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
    logic [15:0] v;
    v = 16'(n);
`ifndef TX_CIPHER_FRAMER_STATS_EN
    v = 16'h0;
`endif
    return v;
  endfunction

  // Reference model: frame position arithmetic on every accepted word, queue compare on every output.
  always @(negedge clk) begin
    if (s_axi_areset) begin
      prev_stall = 1'b0;
    end else begin
      if (s_axis_tvalid && s_axis_tready) begin
        m_key = cfg_mode ? i_keystream_data : i_prbs_data;
        m_len = (cfg_len < 1) ? 1 : cfg_len;
        m_sof = (mdl_idx == 0);
        m_eof = (mdl_idx == m_len - 1);
        exp_q.push_back({s_axis_tdata ^ m_key, m_sof, m_eof});
        mdl_idx = m_eof ? 0 : mdl_idx + 1;
        if (m_eof) mdl_frames++;
        chk("prbs_run_on_accept", o_prbs_run, !cfg_mode);
        chk("ks_ready_on_accept", o_keystream_ready, cfg_mode);
      end else begin
        chk("strobes_without_accept", {o_prbs_run, o_keystream_ready}, 2'b00);
      end
      if (o_prbs_run) begin prbs_pulses++; prbs_adv = 1'b1; end
      if (o_keystream_ready) begin ks_pulses++; ks_adv = 1'b1; end
      if (cfg_mode && !i_keystream_valid && s_axis_tready) tready_bad++;
      m_obs = {m_axis_tdata, m_axis_sof, m_axis_eof};
      if (prev_stall) chk("head_hold", {m_axis_tvalid, m_obs}, {1'b1, prev_head});
      if (m_axis_tvalid && m_axis_tready) begin
        out_q.push_back(m_obs);
        words_out++;
        chk("out_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          m_exp = exp_q.pop_front();
          chk("out_word", m_obs, m_exp);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_head  = m_obs;
    end
  end

  // Keystream sources and optional random sink back-pressure, updated just after each edge.
  always @(posedge clk) begin
    #1;
    if (prbs_adv) begin
      if (prbs_random) i_prbs_data = $urandom;
      prbs_adv = 1'b0;
    end
    case (ks_pattern)
      0: i_keystream_valid = 1'b1;
      1: i_keystream_valid = !i_keystream_valid;
      default: if (ks_adv || !i_keystream_valid) i_keystream_valid = ($urandom_range(0, 2) != 0);
    endcase
    if (ks_adv) begin
      if (ks_random) i_keystream_data = $urandom;
      ks_adv = 1'b0;
    end
    if (rdy_random) m_axis_tready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d);
    bit acc = 1'b0;
    int t = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    while (!acc && t < 300) begin
      @(negedge clk);
      acc = s_axis_tready;
      tick();
      t++;
    end
    s_axis_tvalid = 1'b0;
    chk("word_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      tick();
      t++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic clear_stats();
    out_q.delete();
    prbs_pulses = 0;
    ks_pulses = 0;
    words_out = 0;
    tready_bad = 0;
  endtask

  task automatic set_cfg(input bit mode, input int len);
    cfg_mode = mode;
    cfg_len = len;
    i_encrypt_type = mode;
    i_frame_len = 16'(len);
  endtask

  task automatic stop_and_idle(input string tag);
    i_enable = 1'b0;
    rdy_random = 1'b0;
    m_axis_tready = 1'b1;
    drain();
    repeat (3) tick();
    chk({tag, "_busy"}, o_busy, 1'b0);
    chk({tag, "_tready"}, s_axis_tready, 1'b0);
    chk({tag, "_frames"}, o_frame_count, exp_cnt(mdl_frames));
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] wdata;
  int          stall_acc;
  bit          got;
  time         t0;

  initial begin
    // Reset values, with inputs that would provoke activity if reset leaked
    i_enable = 1'b1;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, 32'h0);
    chk("rst_sof_eof", {m_axis_sof, m_axis_eof}, 2'b00);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_strobes", {o_prbs_run, o_keystream_ready}, 2'b00);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_frames", o_frame_count, 16'h0);
    chk("rst_state", o_dbg_state, 2'd0);
    i_enable = 1'b0;
    s_axis_tvalid = 1'b0;
    tick();
    s_axi_areset = 1'b0;
    tick();

    // Test 1: PRBS, len 4, fixed all-ones key
    clear_stats();
    set_cfg(1'b0, 4);
    prbs_random = 1'b0;
    i_prbs_data = 32'hFFFF_FFFF;
    i_enable = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'h1111_1111;
    @(negedge clk);
    chk("t1_no_accept_in_idle", s_axis_tready, 1'b0);
    tick();
    send_word(32'h1111_1111);
    @(negedge clk);
    chk("t1_latency", {m_axis_tvalid, m_axis_tdata, m_axis_sof}, {1'b1, 32'hEEEE_EEEE, 1'b1});
    tick();
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_word(32'h4444_4444);
    stop_and_idle("t1");
    chk("t1_out_count", out_q.size(), 4);
    chk("t1_w0", out_q[0], {32'hEEEE_EEEE, 2'b10});
    chk("t1_w1", out_q[1], {32'hDDDD_DDDD, 2'b00});
    chk("t1_w2", out_q[2], {32'hCCCC_CCCC, 2'b00});
    chk("t1_w3", out_q[3], {32'hBBBB_BBBB, 2'b01});
    chk("t1_prbs_pulses", prbs_pulses, 4);
    chk("t1_frame_count", o_frame_count, exp_cnt(1));

    // Test 2: ChaCha20, len 2, keystream valid on alternate cycles
    clear_stats();
    set_cfg(1'b1, 2);
    ks_random = 1'b0;
    i_keystream_data = 32'hA5A5_A5A5;
    ks_pattern = 1;
    i_enable = 1'b1;
    for (int i = 0; i < 6; i++) send_word(32'h5A5A_5A5A);
    stop_and_idle("t2");
    chk("t2_words_out", words_out, 6);
    chk("t2_ks_vs_out", ks_pulses, words_out);
    chk("t2_no_prbs", prbs_pulses, 0);
    chk("t2_tready_gated", tready_bad, 0);
    for (int i = 0; i < out_q.size(); i++) chk("t2_data", out_q[i][33:2], 32'hFFFF_FFFF);
    ks_pattern = 0;

    // Test 3: sink stalls for 5 cycles mid-frame
    clear_stats();
    set_cfg(1'b0, 6);
    prbs_random = 1'b1;
    i_prbs_data = $urandom;
    i_enable = 1'b1;
    send_word($urandom);
    send_word($urandom);
    tick();
    m_axis_tready = 1'b0;
    stall_acc = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = $urandom;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      got = s_axis_tready;
      if (got) stall_acc++;
      tick();
      if (got) s_axis_tdata = $urandom;
    end
    @(negedge clk);
    chk("t3_full_tready", s_axis_tready, 1'b0);
    chk("t3_full_tvalid", m_axis_tvalid, 1'b1);
    chk("t3_buffered", stall_acc, 2);
    tick();
    m_axis_tready = 1'b1;
    wdata = s_axis_tdata;
    send_word(wdata);
    send_word($urandom);
    rdy_random = 1'b1;
    for (int i = 0; i < 6; i++) send_word($urandom);
    stop_and_idle("t3");
    chk("t3_words_out", words_out, 12);

    // Test 4: enable drops after the first word of a 3-word frame
    clear_stats();
    set_cfg(1'b0, 3);
    i_enable = 1'b1;
    send_word($urandom);
    i_enable = 1'b0;
    send_word($urandom);
    send_word($urandom);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_closed_after_eof", s_axis_tready, 1'b0);
      tick();
    end
    s_axis_tvalid = 1'b0;
    stop_and_idle("t4");
    chk("t4_out_count", out_q.size(), 3);
    chk("t4_first_sof", out_q[0][1:0], 2'b10);
    chk("t4_last_eof", out_q[2][1:0], 2'b01);
    chk("t4_state", o_dbg_state, 2'd0);

    // Test 4b: enable drops with no frame in progress
    i_enable = 1'b1;
    tick();
    tick();
    chk("t4b_running", s_axis_tready, 1'b1);
    i_enable = 1'b0;
    tick();
    @(negedge clk);
    chk("t4b_idle_state", o_dbg_state, 2'd0);
    chk("t4b_idle_busy", o_busy, 1'b0);
    tick();

    // Test 5: length 0 means 1; every word is sof+eof; counter wraps
    s_axi_areset = 1'b1;
    exp_q.delete();
    mdl_idx = 0;
    mdl_frames = 0;
    tick();
    s_axi_areset = 1'b0;
    tick();
    clear_stats();
    set_cfg(1'b0, 0);
    i_enable = 1'b1;
    for (int i = 1; i <= 65540; i++) begin
      send_word($urandom);
      if (i == 100) t0 = $time;
      if (i == 1100) chk("t5_throughput_cycles", ($time - t0) / 10, 1000);
      if (i == 65535) chk("t5_count_ffff", o_frame_count, exp_cnt(32'hFFFF));
      if (i == 65536) chk("t5_count_wrap", o_frame_count, exp_cnt(0));
    end
    stop_and_idle("t5");
    chk("t5_count_final", o_frame_count, exp_cnt(4));
    chk("t5_last_word", out_q[out_q.size() - 1][1:0], 2'b11);

    // Test 6: reset with two words buffered mid-frame
    clear_stats();
    set_cfg(1'b0, 4);
    i_enable = 1'b1;
    m_axis_tready = 1'b0;
    send_word($urandom);
    send_word($urandom);
    chk("t6_buffer_full", {m_axis_tvalid, s_axis_tready}, 2'b10);
    #2;
    s_axi_areset = 1'b1;
    exp_q.delete();
    mdl_idx = 0;
    mdl_frames = 0;
    #1;
    chk("t6_rst_tvalid", m_axis_tvalid, 1'b0);
    chk("t6_rst_tdata", m_axis_tdata, 32'h0);
    chk("t6_rst_markers", {m_axis_sof, m_axis_eof}, 2'b00);
    chk("t6_rst_tready", s_axis_tready, 1'b0);
    chk("t6_rst_busy", o_busy, 1'b0);
    chk("t6_rst_frames", o_frame_count, 16'h0);
    tick();
    s_axi_areset = 1'b0;
    clear_stats();
    m_axis_tready = 1'b1;
    send_word($urandom);
    drain();
    chk("t6_restart_sof", out_q[0][1], 1'b1);
    send_word($urandom);
    send_word($urandom);
    send_word($urandom);
    stop_and_idle("t6");

    // Test 7: random sessions of mode, length, gaps, keystream stalls and sink stalls
    prbs_random = 1'b1;
    ks_random = 1'b1;
    ks_pattern = 2;
    for (int s = 0; s < 6; s++) begin
      clear_stats();
      set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 5));
      rdy_random = 1'b1;
      i_enable = 1'b1;
      for (int f = 0; f < 3; f++) begin
        for (int w = 0; w < ((cfg_len < 1) ? 1 : cfg_len); w++) begin
          repeat ($urandom_range(0, 2)) tick();
          send_word($urandom);
        end
      end
      stop_and_idle("t7");
      chk("t7_words_out", words_out, 3 * ((cfg_len < 1) ? 1 : cfg_len));
      chk("t7_strobe_total", prbs_pulses + ks_pulses, words_out);
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_cipher_framer.md
# tx_cipher_framer

Transmit-side cipher framer: accepts 32-bit plaintext words on an AXI-Stream input, XORs each word with one word of PRBS or ChaCha20 keystream, and emits ciphertext on an AXI-Stream output with start/end-of-frame markers. It sits between the plaintext source and the link. It drives the PRBS generator and the ChaCha20 stream block exactly as the receive path does, so both ends consume keystream in lockstep. Full back-pressure is supported through a 2-entry output buffer.

## Interface
- C_LEN_WIDTH, 16, width of frame-length and frame-count fields
- s_axi_aclk  in  1  sole clock
- s_axi_areset  in  1  asynchronous, active-high reset
- i_enable  in  1  transmitter enable (from control register)
- i_encrypt_type  in  1  0 = PRBS, 1 = ChaCha20
- i_frame_len  in  C_LEN_WIDTH  words per frame; 0 and 1 both mean 1
- i_prbs_data  in  32  current PRBS word
- o_prbs_run  out  1  one-cycle pulse per PRBS word consumed
- i_keystream_data  in  32  ChaCha20 keystream word
- i_keystream_valid  in  1  keystream word available
- o_keystream_ready  out  1  keystream word consumed this cycle
- s_axis_tvalid / s_axis_tready / s_axis_tdata  in/out/in  1/1/32  plaintext input
- m_axis_tvalid / m_axis_tready / m_axis_tdata  out/in/out  1/1/32  ciphertext output
- m_axis_sof / m_axis_eof  out  1/1  first/last word of frame, qualified by m_axis_tvalid
- o_busy  out  1  state != S_IDLE or output buffer non-empty
- o_frame_count  out  C_LEN_WIDTH  completed frames, wraps

## Operation
- States: S_IDLE, S_RUN, S_LAST.
- S_IDLE → S_RUN when i_enable=1. On entry, latch i_frame_len (clamped to ≥1) and i_encrypt_type, and clear word_cnt.
- Accept condition: acc = s_axis_tvalid && s_axis_tready.
- s_axis_tready = state∈{S_RUN,S_LAST} && buffer not full && (mode==PRBS || i_keystream_valid).
- On acc:
  - Push {tdata ^ key, sof=(word_cnt==0), eof=(word_cnt==len−1)}, where key = i_prbs_data (PRBS) or i_keystream_data (ChaCha20).
  - Pulse o_prbs_run in PRBS mode, or o_keystream_ready in ChaCha20 mode; never both.
  - Increment word_cnt.
- On an acc with eof:
  - word_cnt ← 0; o_frame_count +1.
  - If i_enable=1 and state==S_RUN: re-latch len and mode, stay in S_RUN.
  - Otherwise go to S_IDLE.
- i_enable falling mid-frame: S_RUN → S_LAST; the current frame completes, then S_IDLE.
- i_enable falling with word_cnt==0: immediate S_IDLE.
- Mode and length changes never take effect mid-frame.
- Output buffer: 2-entry FIFO (skid).
  - Pop when m_axis_tvalid && m_axis_tready.
  - Head word and markers stay stable while tvalid=1 and tready=0.
  - Push and pop in the same cycle are legal at any fill level except full-without-pop.
- Reset mid-operation: everything returns to reset values immediately; a partial frame is discarded with no eof emitted.

## Timing
- Reset values:
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_sof=0, m_axis_eof=0
  - s_axis_tready=0, o_prbs_run=0, o_keystream_ready=0
  - o_busy=0, o_frame_count=0
  - state=S_IDLE
- s_axis_tready and the keystream strobes are combinational from state, buffer level and i_keystream_valid.
- Latency: a word accepted in cycle N appears on m_axis_* in cycle N+1 when the buffer was empty.
- Throughput: 1 word/cycle sustained with m_axis_tready=1 and keystream continuously valid.
- PRBS generator advances on the edge after o_prbs_run, so i_prbs_data is fresh in the next cycle.
- First acceptance is possible no earlier than 1 cycle after i_enable rises (IDLE→RUN edge).

## Configuration
- TX_CIPHER_FRAMER_STATS_EN:
  - Defined: o_frame_count counter present as described.
  - Undefined: counter is not implemented and o_frame_count is tied to 0.
  - All other behaviour is identical in both builds.

## Test plan
- PRBS, len=4, i_prbs_data=0xFFFFFFFF, input 0x11111111..0x44444444 → four words 0xEEEEEEEE, 0xDDDDDDDD, 0xCCCCCCCC, 0xBBBBBBBB; sof on word 0, eof on word 3; 4 o_prbs_run pulses; o_frame_count=1.
- ChaCha20, len=2, keystream 0xA5A5A5A5 valid only on alternate cycles, input 0x5A5A5A5A continuous → output 0xFFFFFFFF; s_axis_tready low whenever keystream invalid; o_keystream_ready count equals words out.
- Back-pressure: m_axis_tready=0 for 5 cycles mid-frame → buffer fills at 2, s_axis_tready=0, head word held stable; no loss or duplication after release.
- i_enable drops after word 1 of a len=3 frame → words 2 and 3 still accepted with eof on word 3, then S_IDLE, s_axis_tready=0, o_busy=0 after drain.
- i_frame_len=0 → every word carries both sof=1 and eof=1; o_frame_count increments per word and wraps 0xFFFF→0x0000.
- s_axi_areset asserted mid-frame with buffer holding 2 words → all outputs at reset values in the same cycle; after release with enable high, next output has sof=1.
